// File: rtl/counter_window_arb_if.sv
// Requester-side bundle for counter_window_arb: requests, window lengths,
// grants, the shared counter value, status and the debug FSM state.
interface counter_window_arb_if #(
  parameter int NREQ = 4,
  parameter int CW   = 8
);
  // Handshake: req[i] is a level held by requester i while it wants a window.
  // gnt[i] high means the window is running. done[i] pulses for one cycle
  // when the window ends. req may drop at any time after gnt rises without
  // affecting the window.
  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] len;
  logic [NREQ-1:0]    gnt;
  logic [CW-1:0]      count;
  logic               busy;
  logic [NREQ-1:0]    done;
  logic [1:0]         state;

  modport master (output req, len, input gnt, count, busy, done, state);
  modport slave  (input req, len, output gnt, count, busy, done, state);
endinterface

// File: rtl/counter_window_arb.sv
// Shares one CW-bit up-counter among NREQ requesters, one window at a time.
// Define RR_ARB_EN for round-robin arbitration; otherwise lowest index wins.
module counter_window_arb #(
  parameter int NREQ = 4,
  parameter int CW   = 8
) (
  input logic              clk,
  input logic              reset,
  counter_window_arb_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] done_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   len_q;
  logic            busy_q;

  logic [IW-1:0]   win;
  logic            found;
  logic [NREQ-1:0] win_onehot;

`ifdef RR_ARB_EN
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] cand;

  // Scan upward from the pointer, wrapping, and take the first requester.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IW'((int'(rr_ptr) + i) % NREQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end
`else
  always_comb begin
    found = |bus.req;
    win   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i]) win = IW'(i);
    end
  end
`endif

  assign win_onehot = NREQ'(1) << win;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      count_q <= '0;
      len_q   <= '0;
      busy_q  <= 1'b0;
`ifdef RR_ARB_EN
      rr_ptr  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            gnt_q   <= win_onehot;
            len_q   <= bus.len[win*CW +: CW];
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
`ifdef RR_ARB_EN
            rr_ptr  <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
`endif
          end
        end
        RUN: begin
          // A latched length of 0 underflows to all-ones: a full 2^CW window.
          if (count_q == len_q - CW'(1)) begin
            done_q  <= gnt_q;
            gnt_q   <= '0;
            state_q <= DONE;
          end else begin
            count_q <= count_q + CW'(1);
          end
        end
        DONE: begin
          done_q  <= '0;
          busy_q  <= 1'b0;
          count_q <= '0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          done_q  <= '0;
          busy_q  <= 1'b0;
          count_q <= '0;
        end
      endcase
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.done  = done_q;
  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_counter_window_arb.sv
// Bench for counter_window_arb: a negedge monitor pops expected
// {done one-hot, window length} entries and checks every window.
module tb_counter_window_arb;

  localparam int NREQ = 4;
  localparam int CW   = 8;
  localparam int W    = NREQ + 16;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  counter_window_arb_if #(.NREQ(NREQ), .CW(CW)) bus();

  counter_window_arb #(.NREQ(NREQ), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  int run_cycles = 0;
  int count_err  = 0;
`ifdef RR_ARB_EN
  int model_ptr  = 0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r);
    for (int i = 0; i < NREQ; i++) begin
`ifdef RR_ARB_EN
      if (r[(model_ptr + i) % NREQ]) return (model_ptr + i) % NREQ;
`else
      if (r[i]) return i;
`endif
    end
    return -1;
  endfunction

  task automatic note_grant(input int w);
`ifdef RR_ARB_EN
    model_ptr = (w + 1) % NREQ;
`else
    if (w < 0) $display("note: no winner");
`endif
  endtask

  task automatic push_exp(input int idx, input int l);
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << idx;
    exp_q.push_back({oh, 16'(l)});
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    bus.req = '0;
    bus.len = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
`ifdef RR_ARB_EN
    model_ptr = 0;
`endif
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  // Window monitor: counter sequence, grant length and done identity.
  always @(negedge clk) begin
    if (!reset) begin
      run_cycles = 0;
      count_err  = 0;
    end else begin
      if (bus.gnt != '0) begin
        if (run_cycles == 0) check("gnt_onehot", 32'($onehot(bus.gnt)), 1);
        if (bus.count != CW'(run_cycles)) count_err++;
        run_cycles++;
      end
      if (bus.done != '0) begin
        check("gnt_with_done", bus.gnt, 0);
        check("busy_at_done", bus.busy, 1);
        if (exp_q.size() == 0) begin
          check("unexpected_done", bus.done, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("done_id", bus.done, mon_e[W-1:16]);
          check("win_len", run_cycles, mon_e[15:0]);
          check("count_hold", bus.count, CW'(mon_e[15:0] - 16'd1));
          check("count_seq", count_err, 0);
        end
        run_cycles = 0;
        count_err  = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] r;
    int w;
    int n;
    reset   = 1'b0;
    bus.req = '0;
    bus.len = '0;
    #12;
    check("rst_gnt", bus.gnt, 0);
    check("rst_count", bus.count, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_state", bus.state, 0);
    @(negedge clk);
    reset = 1'b1;

    // Single request, exact cycle timing.
    @(negedge clk);
    bus.len[1*CW +: CW] = 8'd5;
    bus.req = 4'b0010;
    push_exp(1, 5);
    note_grant(1);
    @(posedge clk); #1;
    check("single_gnt", bus.gnt, 4'b0010);
    check("single_count0", bus.count, 0);
    check("single_busy", bus.busy, 1);
    check("single_state_run", bus.state, 1);
    bus.req = '0;
    repeat (4) @(posedge clk); #1;
    check("single_count4", bus.count, 4);
    check("single_gnt_last", bus.gnt, 4'b0010);
    @(posedge clk); #1;
    check("single_gnt_off", bus.gnt, 0);
    check("single_done", bus.done, 4'b0010);
    check("single_busy_done", bus.busy, 1);
    @(posedge clk); #1;
    check("single_done_off", bus.done, 0);
    check("single_busy_off", bus.busy, 0);
    check("single_count_clr", bus.count, 0);
    check("single_state_idle", bus.state, 0);
    wait_drain(10);

    // Contention with requests held.
    do_reset();
`ifdef RR_ARB_EN
    bus.len = {NREQ{8'd2}};
    bus.req = 4'b1111;
    push_exp(0, 2); push_exp(1, 2); push_exp(2, 2); push_exp(3, 2); push_exp(0, 2);
    note_grant(0);
`else
    bus.len = {NREQ{8'd3}};
    bus.req = 4'b1010;
    push_exp(1, 3); push_exp(1, 3); push_exp(1, 3);
`endif
    wait_drain(100);
    bus.req = '0;
    repeat (4) @(negedge clk);
    check("arb_idle", bus.busy, 0);

    // Random request patterns, requests dropped right after the grant.
    do_reset();
    repeat (12) begin
      r = NREQ'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) bus.len[i*CW +: CW] = CW'($urandom_range(1, 12));
      w = pick(r);
      push_exp(w, int'(bus.len[w*CW +: CW]));
      note_grant(w);
      @(negedge clk);
      bus.req = r;
      @(posedge clk); #1;
      check("rand_gnt", bus.gnt, NREQ'(1) << w);
      @(negedge clk);
      bus.req = '0;
      wait_drain(40);
    end

    // Length 0 means a full 256-cycle window.
    @(negedge clk);
    bus.len = '0;
    bus.req = 4'b0001;
    push_exp(0, 256);
    note_grant(0);
    @(posedge clk); #1;
    bus.req = '0;
    wait_drain(300);

    // Request dropped mid-window; window still completes.
    @(negedge clk);
    bus.len[2*CW +: CW] = 8'd6;
    bus.req = 4'b0100;
    push_exp(2, 6);
    note_grant(2);
    @(posedge clk);
    repeat (2) @(negedge clk);
    bus.req = '0;
    wait_drain(20);

    // Asynchronous reset mid-window: everything clears, no done pulse.
    @(negedge clk);
    bus.len[0 +: CW] = 8'd10;
    bus.req = 4'b0001;
    @(posedge clk); #1;
    check("abort_gnt", bus.gnt, 4'b0001);
    bus.req = '0;
    n = 0;
    while (bus.count != 8'd4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach4", bus.count, 4);
    reset = 1'b0;
    #1;
    check("abort_gnt_clr", bus.gnt, 0);
    check("abort_count_clr", bus.count, 0);
    check("abort_busy_clr", bus.busy, 0);
    check("abort_done_clr", bus.done, 0);
    check("abort_state", bus.state, 0);
    repeat (2) @(negedge clk);
    bus.len[0 +: CW] = 8'd3;
    bus.req = 4'b0001;
    reset = 1'b1;
`ifdef RR_ARB_EN
    model_ptr = 0;
`endif
    push_exp(0, 3);
    note_grant(0);
    @(posedge clk); #1;
    check("post_rst_gnt", bus.gnt, 4'b0001);
    check("post_rst_count", bus.count, 0);
    bus.req = '0;
    wait_drain(20);

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
